// File: rtl/dh_pkg.sv
// Shared types and constants for the light-gun flash stage.
package dh_pkg;

    localparam int HV_W  = 11;
    localparam int RGB_W = 12;

    localparam logic [RGB_W-1:0] COLOR_BLACK = 12'h000;
    localparam logic [RGB_W-1:0] COLOR_WHITE = 12'hFFF;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        DARK,
        LIT,
        DONE
    } flash_state_t;

    // How the current pixel's colour is produced.
    typedef enum logic [1:0] {
        PIX_PASS,
        PIX_BLACK,
        PIX_BOX
    } pix_mode_t;

    typedef struct packed {
        logic [HV_W-1:0]  hcount;
        logic [HV_W-1:0]  vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_pix_t;

endpackage

// File: rtl/itf_vga.sv
// VGA timing and pixel bundle passed between drawing stages.
interface itf_vga;

    logic [dh_pkg::HV_W-1:0]  hcount;
    logic [dh_pkg::HV_W-1:0]  vcount;
    logic                     hsync;
    logic                     vsync;
    logic                     hblnk;
    logic                     vblnk;
    logic [dh_pkg::RGB_W-1:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/signal_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs.
module signal_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments make both flops sample together, so the chain really is two stages deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/draw_flash.sv
// Zapper flash sequencer: blacks out the picture, flashes a white target box,
// and reports whether the photodetector saw only the box.
module draw_flash
    import dh_pkg::*;
#(
    parameter int TARGET_WIDTH  = 64,
    parameter int TARGET_HEIGHT = 48,
    parameter int DARK_FRAMES   = 1,
    parameter int LIT_FRAMES    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       shot_req,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    input  logic       target_valid,
    input  logic       gun_photodetector,
    itf_vga.in         in,
    itf_vga.out        out,
    output logic       busy,
    output logic       hit,
    output logic       miss
);

    localparam logic [3:0]      DARK_LAST = 4'(DARK_FRAMES - 1);
    localparam logic [3:0]      LIT_LAST  = 4'(LIT_FRAMES - 1);
    localparam logic [HV_W-1:0] BOX_W_M1  = HV_W'(TARGET_WIDTH - 1);
    localparam logic [HV_W-1:0] BOX_H_M1  = HV_W'(TARGET_HEIGHT - 1);

    flash_state_t state_q, state_d;
    logic [3:0]   count_q, count_d;
    logic [9:0]   tx_q, ty_q;
    logic         tvalid_q;
    logic         dark_seen_q, dark_seen_d;
    logic         lit_seen_q, lit_seen_d;
    logic         latch_target;
    pix_mode_t    mode;
    vga_pix_t     pix_q, pix_d;
    logic         det_s;
    logic         in_box;
    logic [HV_W-1:0] x_lo, x_hi, y_lo, y_hi;

    signal_synchronizer #(.WIDTH(1)) u_det_sync (
        .clk (clk),
        .rst (rst),
        .d_i (gun_photodetector),
        .q_o (det_s)
    );

    // 11-bit bounds: x + width cannot wrap, so an off-screen box clips cleanly.
    assign x_lo   = {1'b0, tx_q};
    assign y_lo   = {1'b0, ty_q};
    assign x_hi   = x_lo + BOX_W_M1;
    assign y_hi   = y_lo + BOX_H_M1;
    assign in_box = tvalid_q
                    && (in.hcount >= x_lo) && (in.hcount <= x_hi)
                    && (in.vcount >= y_lo) && (in.vcount <= y_hi);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        dark_seen_d  = dark_seen_q;
        lit_seen_d   = lit_seen_q;
        latch_target = 1'b0;
        mode         = PIX_PASS;

        unique case (state_q)
            IDLE: begin
                if (shot_req) state_d = ARM;
            end
            ARM: begin
                if (new_frame) begin
                    latch_target = 1'b1;
                    dark_seen_d  = 1'b0;
                    lit_seen_d   = 1'b0;
                    count_d      = '0;
                    state_d      = DARK;
                    mode         = PIX_BLACK;
                end
            end
            DARK: begin
                mode = PIX_BLACK;
                if (det_s) dark_seen_d = 1'b1;
                if (new_frame) begin
                    if (count_q == DARK_LAST) begin
                        count_d = '0;
                        state_d = LIT;
                        mode    = PIX_BOX;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            LIT: begin
                mode = PIX_BOX;
                if (det_s) lit_seen_d = 1'b1;
                if (new_frame) begin
                    if (count_q == LIT_LAST) begin
                        state_d = DONE;
                        mode    = PIX_PASS;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pix_d.hcount = in.hcount;
        pix_d.vcount = in.vcount;
        pix_d.hsync  = in.hsync;
        pix_d.vsync  = in.vsync;
        pix_d.hblnk  = in.hblnk;
        pix_d.vblnk  = in.vblnk;
        pix_d.rgb    = in.rgb;
        if (in.hblnk || in.vblnk) begin
            pix_d.rgb = COLOR_BLACK;
        end else begin
            case (mode)
                PIX_BLACK: pix_d.rgb = COLOR_BLACK;
                PIX_BOX:   pix_d.rgb = in_box ? COLOR_WHITE : COLOR_BLACK;
                default:   pix_d.rgb = in.rgb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            tvalid_q    <= 1'b0;
            dark_seen_q <= 1'b0;
            lit_seen_q  <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dark_seen_q <= dark_seen_d;
            lit_seen_q  <= lit_seen_d;
            pix_q       <= pix_d;
            if (latch_target) begin
                tx_q     <= target_x;
                ty_q     <= target_y;
                tvalid_q <= target_valid;
            end
        end
    end

    assign out.hcount = pix_q.hcount;
    assign out.vcount = pix_q.vcount;
    assign out.hsync  = pix_q.hsync;
    assign out.vsync  = pix_q.vsync;
    assign out.hblnk  = pix_q.hblnk;
    assign out.vblnk  = pix_q.vblnk;
    assign out.rgb    = pix_q.rgb;

    // Any light during the dark frames marks the shot as a cheat or stray light.
    assign busy = (state_q != IDLE);
    assign hit  = (state_q == DONE) && lit_seen_q && !dark_seen_q && tvalid_q;
    assign miss = (state_q == DONE) && !(lit_seen_q && !dark_seen_q && tvalid_q);

endmodule

// File: tb/tb_draw_flash.sv
// Directed bench for draw_flash: pixel tables replayed as compressed frames.
module tb_draw_flash;
    import dh_pkg::*;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] exp_lit;
    } vec_t;

    typedef enum {K_PASS, K_BLACK, K_BOX} kind_t;
    typedef enum {R_NONE, R_HIT, R_MISS} res_t;
    typedef enum {D_OFF, D_ON, D_BOX} det_t;

    logic       clk = 1'b0;
    logic       rst, new_frame, shot_a, shot_b, det, tv;
    logic [9:0] tx, ty;
    logic       busy_a, hit_a, miss_a, busy_b, hit_b, miss_b;

    itf_vga vin ();
    itf_vga vout_a ();
    itf_vga vout_b ();

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tab[29];

    always #5 clk = ~clk;

    draw_flash dut_a (
        .clk (clk), .rst (rst), .new_frame (new_frame), .shot_req (shot_a),
        .target_x (tx), .target_y (ty), .target_valid (tv),
        .gun_photodetector (det), .in (vin), .out (vout_a),
        .busy (busy_a), .hit (hit_a), .miss (miss_a)
    );

    draw_flash #(.DARK_FRAMES(2), .LIT_FRAMES(2)) dut_b (
        .clk (clk), .rst (rst), .new_frame (new_frame), .shot_req (shot_b),
        .target_x (tx), .target_y (ty), .target_valid (tv),
        .gun_photodetector (det), .in (vin), .out (vout_b),
        .busy (busy_b), .hit (hit_b), .miss (miss_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int h, input int v, input bit hb, input bit vb,
                                input logic [11:0] e);
        vec_t r;
        r.h = 11'(h);
        r.v = 11'(v);
        r.hb = hb;
        r.vb = vb;
        r.exp_lit = e;
        return r;
    endfunction

    function automatic logic [11:0] pix_rgb(input int i);
        return 12'h800 | 12'(i * 37);
    endfunction

    // Replays tab[lo..hi] as one frame; the first entry carries new_frame.
    task automatic run_frame(input int lo, input int hi, input bit sel, input kind_t kind,
                             input det_t dm, input res_t res, input int shot_at,
                             input int rst_at, input string tag);
        kind_t       k = kind;
        bit          was_rst = 1'b0;
        logic [11:0] rgb_in, e_rgb;
        logic [25:0] e_fld, a_fld;
        logic [11:0] a_rgb;
        logic        e_busy, e_hit, e_miss, a_busy, a_hit, a_miss;
        for (int i = lo; i <= hi; i++) begin
            int idx = i - lo;
            rgb_in = pix_rgb(i);
            @(negedge clk);
            vin.hcount = tab[i].h;
            vin.vcount = tab[i].v;
            vin.hblnk  = tab[i].hb;
            vin.vblnk  = tab[i].vb;
            vin.hsync  = i[0];
            vin.vsync  = i[2];
            vin.rgb    = rgb_in;
            new_frame  = (idx == 0);
            rst        = (idx == rst_at);
            if (sel) shot_b = (idx == shot_at);
            else     shot_a = (idx == shot_at);
            det = (dm == D_ON) || (dm == D_BOX && tab[i].exp_lit == COLOR_WHITE);
            @(posedge clk);
            #1;
            if (idx == rst_at) begin
                e_fld = '0; e_rgb = '0; e_busy = 0; e_hit = 0; e_miss = 0;
                k = K_PASS;
                was_rst = 1'b1;
            end else begin
                e_fld  = {tab[i].h, tab[i].v, i[0], i[2], tab[i].hb, tab[i].vb};
                e_rgb  = (tab[i].hb || tab[i].vb) ? 12'h000 :
                         (k == K_PASS)  ? rgb_in :
                         (k == K_BLACK) ? 12'h000 : tab[i].exp_lit;
                e_busy = !was_rst && ((k != K_PASS) || (idx == 0 && res != R_NONE)
                                      || (shot_at >= 0 && idx >= shot_at));
                e_hit  = (idx == 0) && (res == R_HIT);
                e_miss = (idx == 0) && (res == R_MISS);
            end
            if (sel) begin
                a_fld = {vout_b.hcount, vout_b.vcount, vout_b.hsync, vout_b.vsync,
                         vout_b.hblnk, vout_b.vblnk};
                a_rgb = vout_b.rgb; a_busy = busy_b; a_hit = hit_b; a_miss = miss_b;
            end else begin
                a_fld = {vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                         vout_a.hblnk, vout_a.vblnk};
                a_rgb = vout_a.rgb; a_busy = busy_a; a_hit = hit_a; a_miss = miss_a;
            end
            check($sformatf("%s[%0d] rgb", tag, idx), 32'(a_rgb), 32'(e_rgb));
            check($sformatf("%s[%0d] fields", tag, idx), 32'(a_fld), 32'(e_fld));
            check($sformatf("%s[%0d] busy", tag, idx), 32'(a_busy), 32'(e_busy));
            check($sformatf("%s[%0d] hit", tag, idx), 32'(a_hit), 32'(e_hit));
            check($sformatf("%s[%0d] miss", tag, idx), 32'(a_miss), 32'(e_miss));
        end
    endtask

    // Standard one-dark/one-lit shot on dut_a with detector on box pixels only.
    task automatic hit_sequence(input string tag);
        tx = 10'd100; ty = 10'd200; tv = 1'b1;
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_NONE, 0,  -1, {tag, "_arm"});
        run_frame(0, 15, 1'b0, K_BLACK, D_OFF, R_NONE, -1, -1, {tag, "_dark"});
        tx = 10'd300; ty = 10'd10; tv = 1'b0;
        run_frame(0, 15, 1'b0, K_BOX,   D_BOX, R_NONE, -1, -1, {tag, "_lit"});
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_HIT,  -1, -1, {tag, "_done"});
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_NONE, -1, -1, {tag, "_after"});
    endtask

    initial begin
        // Target (100,200), 64x48: box covers h 100..163, v 200..247.
        tab[0]  = mk(0,    0,   0, 0, 12'h000);
        tab[1]  = mk(130,  199, 0, 0, 12'h000);
        tab[2]  = mk(99,   200, 0, 0, 12'h000);
        tab[3]  = mk(100,  200, 0, 0, 12'hFFF);
        tab[4]  = mk(163,  200, 0, 0, 12'hFFF);
        tab[5]  = mk(164,  200, 0, 0, 12'h000);
        tab[6]  = mk(130,  220, 1, 0, 12'h000);
        tab[7]  = mk(130,  230, 0, 0, 12'hFFF);
        tab[8]  = mk(100,  247, 0, 0, 12'hFFF);
        tab[9]  = mk(163,  247, 0, 0, 12'hFFF);
        tab[10] = mk(130,  248, 0, 0, 12'h000);
        tab[11] = mk(1300, 248, 1, 0, 12'h000);
        tab[12] = mk(0,    790, 0, 1, 12'h000);
        tab[13] = mk(500,  500, 0, 0, 12'h000);
        tab[14] = mk(10,   700, 0, 0, 12'h000);
        tab[15] = mk(20,   700, 0, 0, 12'h000);
        // Target (1000,740): box clipped to h 1000..1023, v 740..767.
        tab[16] = mk(0,    0,   0, 0, 12'h000);
        tab[17] = mk(1010, 739, 0, 0, 12'h000);
        tab[18] = mk(0,    740, 0, 0, 12'h000);
        tab[19] = mk(999,  740, 0, 0, 12'h000);
        tab[20] = mk(1000, 740, 0, 0, 12'hFFF);
        tab[21] = mk(1023, 740, 0, 0, 12'hFFF);
        tab[22] = mk(1030, 740, 1, 0, 12'h000);
        tab[23] = mk(5,    767, 0, 0, 12'h000);
        tab[24] = mk(1000, 767, 0, 0, 12'hFFF);
        tab[25] = mk(1023, 767, 0, 0, 12'hFFF);
        tab[26] = mk(1010, 768, 0, 1, 12'h000);
        tab[27] = mk(30,   10,  0, 0, 12'h000);
        tab[28] = mk(40,   10,  0, 0, 12'h000);

        rst = 1'b1; new_frame = 1'b1; shot_a = 1'b1; shot_b = 1'b1; det = 1'b1;
        tx = 10'd5; ty = 10'd5; tv = 1'b1;
        vin.hcount = 11'd77; vin.vcount = 11'd33; vin.hsync = 1'b1; vin.vsync = 1'b1;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hABC;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_a", 32'({vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                                  vout_a.hblnk, vout_a.vblnk, vout_a.rgb}), 32'd0);
        check("reset out_b rgb", 32'(vout_b.rgb), 32'd0);
        check("reset flags_a", 32'({busy_a, hit_a, miss_a}), 32'd0);
        check("reset flags_b", 32'({busy_b, hit_b, miss_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0; shot_a = 1'b0; shot_b = 1'b0; det = 1'b0; new_frame = 1'b0;

        // Idle pass-through on a random stream.
        for (int n = 0; n < 40; n++) begin
            logic [11:0] r;
            logic [10:0] h, v;
            logic        hb, vb, hs, vs;
            r  = 12'($urandom);
            h  = 11'($urandom_range(0, 1343));
            v  = 11'($urandom_range(0, 805));
            hb = ($urandom_range(0, 3) == 0);
            vb = ($urandom_range(0, 3) == 0);
            hs = 1'($urandom);
            vs = 1'($urandom);
            @(negedge clk);
            vin.hcount = h; vin.vcount = v; vin.hsync = hs; vin.vsync = vs;
            vin.hblnk = hb; vin.vblnk = vb; vin.rgb = r;
            new_frame = 1'($urandom);
            det = 1'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("idle[%0d] rgb", n), 32'(vout_a.rgb), 32'((hb || vb) ? 12'h000 : r));
            check($sformatf("idle[%0d] fields", n),
                  32'({vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                       vout_a.hblnk, vout_a.vblnk}), 32'({h, v, hs, vs, hb, vb}));
            check($sformatf("idle[%0d] busy", n), 32'(busy_a), 32'd0);
        end

        // Hit, with shot_req coinciding with new_frame and the target changed after the latch.
        hit_sequence("hit");

        // Detector high throughout: light seen in the dark frame means miss.
        tx = 10'd100; ty = 10'd200; tv = 1'b1;
        run_frame(0, 15, 1'b0, K_PASS,  D_ON,  R_NONE, 3,  -1, "cheat_arm");
        run_frame(0, 15, 1'b0, K_BLACK, D_ON,  R_NONE, -1, -1, "cheat_dark");
        run_frame(0, 15, 1'b0, K_BOX,   D_ON,  R_NONE, -1, -1, "cheat_lit");
        run_frame(0, 15, 1'b0, K_PASS,  D_ON,  R_MISS, -1, -1, "cheat_done");
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_NONE, -1, -1, "cheat_after");

        // Invalid target at the latch; later valid=1 and a second shot are both ignored.
        tv = 1'b0;
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_NONE, 2,  -1, "inv_arm");
        run_frame(0, 15, 1'b0, K_BLACK, D_OFF, R_NONE, 5,  -1, "inv_dark");
        tv = 1'b1;
        run_frame(0, 15, 1'b0, K_BLACK, D_BOX, R_NONE, -1, -1, "inv_lit");
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_MISS, -1, -1, "inv_done");
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_NONE, -1, -1, "inv_after");

        // Clipped box on the two-dark/two-lit instance.
        tx = 10'd1000; ty = 10'd740; tv = 1'b1;
        run_frame(16, 28, 1'b1, K_PASS,  D_OFF, R_NONE, 0,  -1, "edge_arm");
        run_frame(16, 28, 1'b1, K_BLACK, D_OFF, R_NONE, -1, -1, "edge_dark0");
        run_frame(16, 28, 1'b1, K_BLACK, D_OFF, R_NONE, -1, -1, "edge_dark1");
        run_frame(16, 28, 1'b1, K_BOX,   D_BOX, R_NONE, -1, -1, "edge_lit0");
        run_frame(16, 28, 1'b1, K_BOX,   D_BOX, R_NONE, -1, -1, "edge_lit1");
        run_frame(16, 28, 1'b1, K_PASS,  D_OFF, R_HIT,  -1, -1, "edge_done");
        run_frame(16, 28, 1'b1, K_PASS,  D_OFF, R_NONE, -1, -1, "edge_after");

        // Reset in the middle of the dark frame, then a normal shot.
        tx = 10'd100; ty = 10'd200; tv = 1'b1;
        run_frame(0, 15, 1'b0, K_PASS,  D_ON,  R_NONE, 0,  -1, "rst_arm");
        run_frame(0, 15, 1'b0, K_BLACK, D_ON,  R_NONE, -1, 4,  "rst_dark");
        run_frame(0, 15, 1'b0, K_PASS,  D_OFF, R_NONE, -1, -1, "rst_resume");
        hit_sequence("rst_hit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_flash.md
Name: draw_flash

Overview:
- Final VGA stage of the light-gun path. It sits between draw_duck and the r/g/b/hs/vs pins.
- On a shot request it runs the classic zapper sequence: one or more all-black frames, then frames with a white target box on black.
- It samples the gun photodetector during both phases and reports a single hit or miss pulse.
- When idle it passes the picture through unchanged, with one register stage.

Parameters:
- TARGET_WIDTH, 64, width in pixels of the white box.
- TARGET_HEIGHT, 48, height in pixels of the white box.
- DARK_FRAMES, 1, number of all-black frames, 1..15.
- LIT_FRAMES, 1, number of box frames, 1..15.

Ports:
- clk  in  1  pixel clock, 65 MHz.
- rst  in  1  synchronous, active-high reset.
- new_frame  in  1  one-cycle pulse in the same cycle that in carries hcount=0, vcount=0.
- shot_req  in  1  one-cycle shot request from the trigger controller.
- target_x  in  10  left edge of the target, in pixels.
- target_y  in  10  top edge of the target, in pixels.
- target_valid  in  1  target is currently on screen.
- gun_photodetector  in  1  raw asynchronous detector input, active high.
- in  itf_vga in-modport  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb[11:0].
- out  itf_vga out-modport  same fields, registered.
- busy  out  1  a sequence is in progress.
- hit  out  1  one-cycle pulse: shot hit.
- miss  out  1  one-cycle pulse: shot missed.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values: state IDLE; all out fields 0; busy, hit, miss all 0; frame counter, latched target and detector flags all cleared.
- Latency: every out field equals the corresponding in field delayed exactly 1 clk. Only rgb is ever overridden.
- Detector input: gun_photodetector passes through a 2-FF synchronizer to give det_s, adding 2 cycles of latency.
- State IDLE:
  - rgb is passed through.
  - shot_req moves to ARM.
- State ARM:
  - rgb is passed through.
  - Waits for new_frame.
  - On new_frame: latch target_x, target_y and target_valid; clear dark_seen and lit_seen; set frame count to 0; go to DARK.
  - The DARK override starts with the pixel sampled in that same cycle, so the first pixel of the frame is already black.
- State DARK:
  - rgb is 12'h000 for every pixel.
  - Any cycle with det_s=1 sets dark_seen.
  - On new_frame: increment the count. When the count reaches DARK_FRAMES, reset it to 0 and go to LIT, with the override starting at that frame's first pixel.
- State LIT:
  - rgb is 12'hFFF where the latched target is valid and x ≤ hcount ≤ x+TARGET_WIDTH−1 and y ≤ vcount ≤ y+TARGET_HEIGHT−1. Otherwise rgb is 12'h000.
  - Any cycle with det_s=1 sets lit_seen.
  - On new_frame with the count at LIT_FRAMES−1, go to DONE. The frame that starts there is not overridden.
- Box comparisons: done at 11 bits, so x+W never wraps. A box partly off-screen is naturally clipped.
- Blanking: whenever in.hblnk or in.vblnk is set, rgb is 0 in all states.
- State DONE (one cycle):
  - If lit_seen & !dark_seen & latched valid, pulse hit; otherwise pulse miss.
  - Then go to IDLE.
  - dark_seen acts as an anti-cheat / ambient-light rejection.
- busy is 1 in ARM, DARK, LIT and DONE.
- Ignored inputs: shot_req is ignored while busy. Changes on target_* after the latch are ignored.
- hit and miss are mutually exclusive. Exactly one of them pulses per accepted shot.
- shot_req and new_frame in the same cycle while IDLE: go to ARM only, so the sequence starts at the next frame.
- Reset asserted mid-sequence: return to IDLE. No hit/miss pulse is emitted. out is all 0 for the reset cycle and then resumes as pass-through.

Decomposition:
- Package dh_pkg holds:
  - the state enum flash_state_t {IDLE, ARM, DARK, LIT, DONE};
  - the constants COLOR_BLACK=12'h000 and COLOR_WHITE=12'hFFF;
  - the width constant for hcount/vcount.
- Sub-module signal_synchronizer (2-FF, parameterised width) for gun_photodetector.
- Everything else, including the FSM, counter, box compare and output register, lives in draw_flash.

Test Plan:
- Idle pass-through: random in stream, no shot → out equals in delayed 1 cycle, bit-exact; busy=0 throughout.
- Hit case: target (100,200), valid, detector high only on box pixels of the LIT frame (modelled) → one frame all black, then box at hcount 100..163 / vcount 200..247 white; hit pulses for exactly 1 cycle after the LIT frame; miss never asserts.
- Cheat case: detector held high throughout → dark_seen set; miss pulses for 1 cycle; hit=0.
- Invalid target: target_valid=0 at the latch → LIT frame entirely black; miss pulses; a shot_req issued mid-sequence causes no second sequence.
- Edge clip: target (1000,740) with DARK_FRAMES=2, LIT_FRAMES=2 → two black frames, then two frames with the box clipped to hcount 1000..1023 / vcount 740..767; no wrap artefacts at hcount 0.
- Reset mid-DARK: rst asserted during frame 1 → state IDLE next cycle; hit=miss=0; pass-through resumes; a subsequent shot completes normally.
